// File: rtl/team_06_esp_pkg.sv
// Shared types and defaults for the ESP transmit scheduler.
package team_06_esp_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEF_GAP_CYCLES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STALL = 2'd2,
        GAP   = 2'd3
    } esp_tx_state_t;

endpackage

// File: rtl/team_06_esp_tx_sched_if.sv
// Requester and serializer signals of the ESP transmit scheduler.
interface team_06_esp_tx_sched_if #(
    parameter int NUM_REQ = 2
);
    import team_06_esp_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        grant;
    logic                      ser_cs;
    logic [BYTE_W-1:0]         ser_data;
    logic                      ser_start;
    logic                      ser_done;
    logic                      busy;
    logic                      err_timeout;
    logic                      err_clr;

    modport slave (
        input  req_valid, req_data, req_last, ser_done, err_clr,
        output req_ready, grant, ser_cs, ser_data, ser_start, busy, err_timeout
    );

    modport master (
        output req_valid, req_data, req_last, ser_done, err_clr,
        input  req_ready, grant, ser_cs, ser_data, ser_start, busy, err_timeout
    );

endinterface

// File: rtl/team_06_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after rr_ptr, wrapping.
module team_06_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/team_06_esp_tx_sched.sv
// Round-robin frame scheduler in front of the single SPI-to-ESP byte serializer.
// IDLE: no owner | WAIT: byte in flight | STALL: owner has no next byte yet | GAP: cs low before next frame
module team_06_esp_tx_sched
    import team_06_esp_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic                   clk,
    input logic                   rst,
    team_06_esp_tx_sched_if.slave bus
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    esp_tx_state_t      state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0]   gidx, gidx_n;
    logic               last_q, last_n;
    logic [NUM_REQ-1:0] grant_q, grant_n;
    logic               cs_q, cs_n;
    logic [BYTE_W-1:0]  data_q, data_n;
    logic               start_q, start_n;
    logic [NUM_REQ-1:0] ready_q, ready_n;
    logic               busy_q, busy_n;
    logic               err_q, err_n;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_found;

    logic               load, finish, err_set;
    logic [IDX_W-1:0]   load_idx;
    logic [NUM_REQ-1:0] load_oh;

    team_06_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr),
        .grant  (arb_grant),
        .idx    (arb_idx),
        .found  (arb_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rr_ptr  <= IDX_W'(NUM_REQ - 1);
            gidx    <= '0;
            last_q  <= 1'b0;
            grant_q <= '0;
            cs_q    <= 1'b0;
            data_q  <= '0;
            start_q <= 1'b0;
            ready_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rr_ptr  <= rr_ptr_n;
            gidx    <= gidx_n;
            last_q  <= last_n;
            grant_q <= grant_n;
            cs_q    <= cs_n;
            data_q  <= data_n;
            start_q <= start_n;
            ready_q <= ready_n;
            busy_q  <= busy_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = (cnt == '1) ? cnt : cnt + CNT_W'(1);
        rr_ptr_n = rr_ptr;
        gidx_n   = gidx;
        last_n   = last_q;
        grant_n  = grant_q;
        cs_n     = cs_q;
        data_n   = data_q;
        start_n  = 1'b0;
        ready_n  = '0;
        load     = 1'b0;
        finish   = 1'b0;
        err_set  = 1'b0;
        load_idx = gidx;
        load_oh  = NUM_REQ'(1) << gidx;

        case (state)
            IDLE: begin
                if (arb_found) begin
                    load     = 1'b1;
                    load_idx = arb_idx;
                    load_oh  = arb_grant;
                end
            end
            WAIT: begin
                // a completing byte takes precedence over an expiring timer
                if (bus.ser_done) begin
                    if (last_q) begin
                        finish = 1'b1;
                    end else if (bus.req_valid[gidx]) begin
                        load = 1'b1;
                    end else begin
                        state_n = STALL;
                    end
                end else if (cnt == TMO_LAST) begin
                    finish  = 1'b1;
                    err_set = 1'b1;
                end
            end
            STALL: begin
                if (bus.req_valid[gidx]) begin
                    load = 1'b1;
                end else if (cnt == TMO_LAST) begin
                    finish  = 1'b1;
                    err_set = 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            state_n = WAIT;
            cnt_n   = '0;
            gidx_n  = load_idx;
            last_n  = bus.req_last[load_idx];
            grant_n = load_oh;
            cs_n    = 1'b1;
            data_n  = bus.req_data[int'(load_idx)*BYTE_W +: BYTE_W];
            start_n = 1'b1;
            ready_n = load_oh;
        end

        if (finish) begin
            state_n  = GAP;
            cnt_n    = '0;
            rr_ptr_n = gidx;
            grant_n  = '0;
            cs_n     = 1'b0;
        end

        err_n  = err_set | (err_q & ~bus.err_clr);
        busy_n = (state_n != IDLE);
    end

    assign bus.req_ready   = ready_q;
    assign bus.grant       = grant_q;
    assign bus.ser_cs      = cs_q;
    assign bus.ser_data    = data_q;
    assign bus.ser_start   = start_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_q;

endmodule

// File: doc/team_06_esp_tx_sched.md
Name: team_06_esp_tx_sched

Overview:
Frame-level scheduler that shares the single SPI-to-ESP byte serializer between several on-chip requesters, e.g. keypad/event logic and the status reporter.
- Grants the serializer round-robin, one whole frame per grant.
- Feeds bytes to the serializer one at a time and holds chip-select across the frame.
- Enforces an inter-frame gap.
- Aborts a frame on serializer timeout.
- Sits between requesters and the serializer inside the team_06 top.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
GAP_CYCLES, 4, clk cycles with ser_cs low between frames (>=1).
TIMEOUT_CYCLES, 64, max cycles waiting for ser_done or for the next byte before abort.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a byte on req_data slice i
req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
req_last  in  NUM_REQ  byte of requester i is the final byte of its frame
req_ready  out  NUM_REQ  one-cycle pulse: byte of requester i consumed
grant  out  NUM_REQ  one-hot owner of the current frame; 0 when idle
ser_cs  out  1  serializer chip-select, active-high, held for the whole frame
ser_data  out  8  byte to the serializer parallel_in
ser_start  out  1  one-cycle pulse: serializer loads ser_data
ser_done  in  1  one-cycle pulse from serializer: byte shifted out
busy  out  1  high in any state except IDLE
err_timeout  out  1  sticky: a frame was aborted
err_clr  in  1  synchronous clear of err_timeout

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=NUM_REQ-1, all outputs 0. No partial frame survives; ser_cs drops immediately.
- States: IDLE, WAIT, STALL, GAP. All outputs registered.
- IDLE, any req_valid high at edge N:
  - Pick the first requester at or after rr_ptr+1, mod NUM_REQ.
  - At edge N+1: grant=onehot(g), ser_cs=1, ser_data=req_data[g], ser_start=1, req_ready[g]=1.
  - Capture last_q=req_last[g], clear tmo counter, go WAIT.
- ser_start and req_ready: exactly one cycle each, always simultaneous.
- WAIT:
  - tmo counter increments each cycle.
  - ser_done with last_q=1: ser_cs=0 next cycle, grant=0, rr_ptr=g, go GAP.
  - ser_done, last_q=0, req_valid[g]=1: load the next byte as in IDLE (same one-cycle latency), counter cleared, stay WAIT.
  - ser_done, last_q=0, req_valid[g]=0: go STALL, ser_cs stays 1.
- STALL:
  - Counter keeps counting.
  - req_valid[g]=1: load byte, go WAIT.
  - Other requesters are ignored.
- Timeout, in WAIT or STALL, when the counter reaches TIMEOUT_CYCLES-1 without a progress event:
  - ser_cs=0, grant=0, err_timeout=1, rr_ptr=g, go GAP.
  - ser_done in the same cycle wins over timeout.
- GAP: ser_cs=0 for exactly GAP_CYCLES cycles, then IDLE. Requests are held off, including the same requester.
- ser_done outside WAIT: ignored.
- err_clr and timeout in the same cycle: set wins.
- Fairness: after requester g is served, the others get priority. A requester with continuous valid is served every other frame when NUM_REQ=2.
- Counter width: $clog2(max(GAP_CYCLES, TIMEOUT_CYCLES))+1. Saturates, no wrap.

Decomposition:
- Package team_06_esp_pkg:
  - state enum esp_tx_state_t {IDLE, WAIT, STALL, GAP}.
  - Default GAP/TIMEOUT constants.
  - BYTE_W=8.
- One sub-module, team_06_rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, index.
- Counter and FSM stay in the top block.

Test Plan:
- Bench model: serializer pulses ser_done 9 cycles after ser_start. Config: NUM_REQ=2, GAP=4, TIMEOUT=64.
- Single frame: req0 sends 0x43 (last=0), then 0x01 (last=1).
  - ser_start twice; ser_data 0x43 then 0x01.
  - ser_cs high continuously from the first start until 1 cycle after the 2nd ser_done.
  - Then 4 cycles low; err_timeout=0.
- Contention: req0 and req1 both valid with 1-byte frames 0x20 / 0x53, continuously.
  - Grant order: req0, req1, req0, req1.
  - GAP of 4 cycles between frames.
- Stall: req1 frame 0xFF, then valid dropped for 20 cycles, then 0x4F with last=1.
  - ser_cs stays high through the stall.
  - Frame completes; no error.
- Timeout: serializer model never returns ser_done after 0x4F.
  - ser_cs drops 64 cycles after ser_start; err_timeout=1.
  - Then err_clr clears it.
- Reset mid-frame: rst asserted 3 cycles after ser_start.
  - ser_cs, grant and busy go 0 asynchronously.
  - After release: IDLE, and req0 is served first.
